// File: rtl/n_clic_vec.sv
// n_clic_vec: nested, vectored, priority-based interrupt controller.
//
// Sits beside the decoder/rf_stack. External sources set per-vector pending
// bits (edge or level triggered). The highest-priority pending and enabled
// vector above the running level preempts the program, and its handler
// address is steered onto the pc. A hardware return stack restores
// {pc, level} when the handler jumps to ExitAddr. Tail-chaining skips the
// pop when another vector is waiting above the stacked level.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   csr_enable        CSR instruction valid this cycle
//   csr_addr          CSR address (config at CfgBase+i, handler at VecBase+i)
//   rs1_zimm          immediate operand for the *I CSR ops
//   rs1_data          register operand for the register CSR ops
//   csr_op            RW/RS/RC and their immediate variants
//   pc_in             next pc from the branch mux
//   ext_irq           external interrupt sources, synchronous to clk
//   csr_out           pre-write value of the addressed CSR (combinational)
//   int_addr          pc to load on take/return
//   pc_interrupt_sel  selects int_addr into the pc
//   level_out         current running priority (registered)
//   interrupt_out     one-cycle strobe on handler entry (RA write)

package n_clic_vec_pkg;
  localparam int IMemAddrWidth = 16;

  typedef enum logic [2:0] {
    CSR_RW  = 3'b001,
    CSR_RS  = 3'b010,
    CSR_RC  = 3'b011,
    CSR_RWI = 3'b101,
    CSR_RSI = 3'b110,
    CSR_RCI = 3'b111
  } csr_op_t;

  typedef enum logic {
    PC_NORMAL    = 1'b0,
    PC_INTERRUPT = 1'b1
  } pc_interrupt_mux_t;
endpackage

module n_clic_vec
  import n_clic_vec_pkg::*;
#(
  parameter int                   VecNum    = 8,
  parameter int                   PrioWidth = 3,
  parameter int                   AddrWidth = IMemAddrWidth,
  parameter logic [11:0]          CfgBase   = 12'hB00,
  parameter logic [11:0]          VecBase   = 12'hB20,
  parameter logic [AddrWidth-1:0] ExitAddr  = {AddrWidth{1'b1}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 csr_enable,
  input  logic [11:0]          csr_addr,
  input  logic [4:0]           rs1_zimm,
  input  logic [31:0]          rs1_data,
  input  csr_op_t              csr_op,
  input  logic [AddrWidth-1:0] pc_in,
  input  logic [VecNum-1:0]    ext_irq,
  output logic [31:0]          csr_out,
  output logic [AddrWidth-1:0] int_addr,
  output pc_interrupt_mux_t    pc_interrupt_sel,
  output logic [PrioWidth-1:0] level_out,
  output logic                 interrupt_out
);

  localparam int IdxW       = (VecNum > 1) ? $clog2(VecNum) : 1;
  localparam int StackDepth = (1 << PrioWidth) - 1;
  localparam int CfgW       = PrioWidth + 3;

  logic [VecNum-1:0]    pending, enable, edge_mode, irq_prev, pending_next;
  logic [PrioWidth-1:0] prio     [VecNum];
  logic [AddrWidth-1:0] handler  [VecNum];
  logic [AddrWidth-1:0] stack_pc [StackDepth];
  logic [PrioWidth-1:0] stack_lvl[StackDepth];
  logic [PrioWidth-1:0] sp;

  logic [11:0]     cfg_off, vec_off;
  logic            cfg_hit, vec_hit, cfg_we, vec_we, csr_wr;
  logic [IdxW-1:0] cfg_idx, vec_idx;
  logic [31:0]     operand, wdata;
  logic            unused_wdata;

  logic                 cand_found, cand_valid;
  logic [IdxW-1:0]      cand_idx;
  logic [PrioWidth-1:0] cand_prio;
  logic                 is_exit, do_take, do_ret, do_tail, do_pop;
  logic [PrioWidth-1:0] top;
  logic [PrioWidth-1:0] top_lvl;
  logic [AddrWidth-1:0] top_pc;

  // CSR address decode: both register banks are contiguous windows.
  assign cfg_off = csr_addr - CfgBase;
  assign vec_off = csr_addr - VecBase;
  assign cfg_hit = (csr_addr >= CfgBase) && (cfg_off < 12'(VecNum));
  assign vec_hit = (csr_addr >= VecBase) && (vec_off < 12'(VecNum));
  assign cfg_idx = cfg_off[IdxW-1:0];
  assign vec_idx = vec_off[IdxW-1:0];

  // Old value read-out and write-data formation. Set/clear with a zero
  // operand must not write, so the pending bit is not disturbed by reads.
  always_comb begin
    csr_out = '0;
    if (cfg_hit)
      csr_out = 32'({prio[cfg_idx], edge_mode[cfg_idx], enable[cfg_idx], pending[cfg_idx]});
    else if (vec_hit)
      csr_out = 32'(handler[vec_idx]);

    operand = (csr_op inside {CSR_RWI, CSR_RSI, CSR_RCI}) ? {27'b0, rs1_zimm} : rs1_data;
    wdata   = csr_out;
    csr_wr  = 1'b0;
    case (csr_op)
      CSR_RW, CSR_RWI: begin
        wdata  = operand;
        csr_wr = 1'b1;
      end
      CSR_RS, CSR_RSI: begin
        wdata  = csr_out | operand;
        csr_wr = (operand != 32'b0);
      end
      CSR_RC, CSR_RCI: begin
        wdata  = csr_out & ~operand;
        csr_wr = (operand != 32'b0);
      end
      default: begin
        wdata  = csr_out;
        csr_wr = 1'b0;
      end
    endcase
  end

  assign cfg_we       = csr_enable && cfg_hit && csr_wr;
  assign vec_we       = csr_enable && vec_hit && csr_wr;
  assign unused_wdata = ^wdata;

  // Candidate search: strict '>' keeps the lowest index on ties and also
  // excludes priority 0 (thread mode) from ever being a candidate.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_prio  = '0;
    for (int i = 0; i < VecNum; i++) begin
      if (pending[i] && enable[i] && (prio[i] > cand_prio)) begin
        cand_found = 1'b1;
        cand_idx   = IdxW'(i);
        cand_prio  = prio[i];
      end
    end
  end

  // Take / return / tail-chain decisions, all from pre-write state.
  assign cand_valid = cand_found && (cand_prio > level_out);
  assign is_exit    = (pc_in == ExitAddr);
  assign top        = sp - PrioWidth'(1);
  assign top_lvl    = stack_lvl[top];
  assign top_pc     = stack_pc[top];
  assign do_take    = cand_valid && !is_exit;
  assign do_ret     = is_exit && (sp != '0);
  assign do_tail    = do_ret && cand_found && (cand_prio > top_lvl);
  assign do_pop     = do_ret && !do_tail;

  // Pc steering outputs are purely combinational.
  always_comb begin
    interrupt_out    = do_take || do_tail;
    pc_interrupt_sel = (do_take || do_ret) ? PC_INTERRUPT : PC_NORMAL;
    int_addr         = '0;
    if (do_take || do_tail)
      int_addr = handler[cand_idx];
    else if (do_pop)
      int_addr = top_pc;
  end

  // Pending update: CSR write first, then acceptance clears, and a hardware
  // set has the last word so a simultaneous CSR clear cannot lose an event.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < VecNum; i++) begin
      if (cfg_we && (cfg_idx == IdxW'(i)))
        pending_next[i] = wdata[0];
      if ((do_take || do_tail) && (cand_idx == IdxW'(i)))
        pending_next[i] = 1'b0;
      if (edge_mode[i] ? (ext_irq[i] && !irq_prev[i]) : ext_irq[i])
        pending_next[i] = 1'b1;
    end
  end

  // Architectural state: config, handlers, edge history, level and stack
  // pointer. Reset drops the stack by clearing the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      enable    <= '0;
      edge_mode <= '0;
      irq_prev  <= '0;
      level_out <= '0;
      sp        <= '0;
      for (int i = 0; i < VecNum; i++) begin
        prio[i]    <= '0;
        handler[i] <= '0;
      end
    end else begin
      irq_prev <= ext_irq;
      pending  <= pending_next;
      for (int i = 0; i < VecNum; i++) begin
        if (cfg_we && (cfg_idx == IdxW'(i))) begin
          enable[i]    <= wdata[1];
          edge_mode[i] <= wdata[2];
          prio[i]      <= wdata[CfgW-1:3];
        end
        if (vec_we && (vec_idx == IdxW'(i)))
          handler[i] <= wdata[AddrWidth-1:0];
      end
      if (do_take || do_tail)
        level_out <= cand_prio;
      else if (do_pop)
        level_out <= top_lvl;
      if (do_take)
        sp <= sp + PrioWidth'(1);
      else if (do_pop)
        sp <= sp - PrioWidth'(1);
    end
  end

  // Stack storage needs no reset; only entries below sp are ever read.
  // Levels strictly increase on every push, so sp never exceeds the depth.
  always_ff @(posedge clk) begin
    if (!reset && do_take) begin
      stack_pc[sp]  <= pc_in;
      stack_lvl[sp] <= level_out;
    end
  end

endmodule
